// File: rtl/pu_msp430_ram_arb.sv
// ============================================================================
// Module   : pu_msp430_ram_arb
// Brief    : Two-port arbiter sharing one single-port MSP430 data RAM between
//            the CPU data bus (port 0, fixed priority) and a secondary master
//            (port 1). Grants are combinational; read data returns one cycle
//            later with a valid strobe and a per-port hold register. A
//            starvation counter bounds how long port 1 can be denied.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pu_msp430_ram_arb #(
    parameter int ADDR_MSB = 6,
    parameter int MEM_SIZE = 256,
    parameter int MAX_WAIT = 3
) (
    input  logic              ram_clk,
    input  logic              ram_rst_n,
    // port 0: CPU data bus
    input  logic              p0_req,
    input  logic [ADDR_MSB:0] p0_addr,
    input  logic [1:0]        p0_wen,
    input  logic [15:0]       p0_din,
    output logic              p0_gnt,
    output logic [15:0]       p0_dout,
    output logic              p0_dvld,
    output logic              p0_err,
    // port 1: DMA / debug
    input  logic              p1_req,
    input  logic [ADDR_MSB:0] p1_addr,
    input  logic [1:0]        p1_wen,
    input  logic [15:0]       p1_din,
    output logic              p1_gnt,
    output logic [15:0]       p1_dout,
    output logic              p1_dvld,
    output logic              p1_err,
    // RAM side
    output logic [ADDR_MSB:0] ram_addr,
    output logic              ram_cen,
    output logic [1:0]        ram_wen,
    output logic [15:0]       ram_din,
    input  logic [15:0]       ram_dout
);

    localparam logic [31:0] c_WORDS    = 32'(MEM_SIZE / 2);
    localparam logic [3:0]  c_MAX_WAIT = 4'(MAX_WAIT);

    logic [3:0]        starve_q, starve_d;
    logic              rd_pend_q, rd_pend_d;
    logic              rd_port_q, rd_port_d;
    logic              rd_oor_q, rd_oor_d;
    logic [1:0]        err_q, err_d;
    logic [15:0]       hold0_q, hold0_d;
    logic [15:0]       hold1_q, hold1_d;

    logic              w_p1_win;
    logic              w_g0, w_g1, w_any;
    logic [ADDR_MSB:0] w_addr;
    logic [31:0]       w_addr_ext;
    logic [1:0]        w_wen;
    logic [15:0]       w_din;
    logic              w_in_range;
    logic              w_is_read;
    logic              w_dvld0, w_dvld1;
    logic [15:0]       w_rdata;

    // Fixed-priority arbitration, overridden for port 1 once it has starved.
    // Gating with the reset input keeps the RAM idle while reset is asserted.
    always_comb begin
        w_p1_win = (starve_q == c_MAX_WAIT);
        w_g0     = ram_rst_n & p0_req & ~(p1_req & w_p1_win);
        w_g1     = ram_rst_n & p1_req & (~p0_req | w_p1_win);
        w_any    = w_g0 | w_g1;
    end

    // Mux the granted port onto the RAM; out-of-range accesses keep CEN high.
    always_comb begin
        w_addr     = w_g1 ? p1_addr : p0_addr;
        w_wen      = w_g1 ? p1_wen  : p0_wen;
        w_din      = w_g1 ? p1_din  : p0_din;
        w_addr_ext = 32'(w_addr);
        w_in_range = (w_addr_ext < c_WORDS);
        w_is_read  = w_any & (w_wen == 2'b11);
        ram_cen    = ~(w_any & w_in_range);
        ram_addr   = w_any ? w_addr : '0;
        ram_wen    = w_any ? w_wen  : 2'b11;
        ram_din    = w_any ? w_din  : 16'h0000;
    end

    // Read return path: pass RAM data through in the valid cycle, otherwise
    // present the last value captured for that port. Out-of-range reads
    // return zero instead of whatever the RAM output happens to hold.
    always_comb begin
        w_dvld0 = rd_pend_q & ~rd_port_q;
        w_dvld1 = rd_pend_q &  rd_port_q;
        w_rdata = rd_oor_q ? 16'h0000 : ram_dout;
        hold0_d = w_dvld0 ? w_rdata : hold0_q;
        hold1_d = w_dvld1 ? w_rdata : hold1_q;
        p0_dout = hold0_d;
        p1_dout = hold1_d;
    end

    // Next-state for read tracking, error pulses and the starvation counter.
    always_comb begin
        rd_pend_d = w_is_read;
        rd_port_d = w_is_read ? w_g1 : rd_port_q;
        rd_oor_d  = w_is_read ? ~w_in_range : rd_oor_q;
        err_d     = {w_g1 & ~w_in_range, w_g0 & ~w_in_range};
        if (p1_req && !w_g1) begin
            starve_d = (starve_q >= c_MAX_WAIT) ? c_MAX_WAIT : starve_q + 4'd1;
        end else begin
            starve_d = 4'd0;
        end
    end

    // State registers; async reset also drops any in-flight read.
    always_ff @(posedge ram_clk or negedge ram_rst_n) begin
        if (!ram_rst_n) begin
            starve_q  <= 4'd0;
            rd_pend_q <= 1'b0;
            rd_port_q <= 1'b0;
            rd_oor_q  <= 1'b0;
            err_q     <= 2'b00;
            hold0_q   <= 16'h0000;
            hold1_q   <= 16'h0000;
        end else begin
            starve_q  <= starve_d;
            rd_pend_q <= rd_pend_d;
            rd_port_q <= rd_port_d;
            rd_oor_q  <= rd_oor_d;
            err_q     <= err_d;
            hold0_q   <= hold0_d;
            hold1_q   <= hold1_d;
        end
    end

    assign p0_gnt  = w_g0;
    assign p1_gnt  = w_g1;
    assign p0_dvld = w_dvld0;
    assign p1_dvld = w_dvld1;
    assign p0_err  = err_q[0];
    assign p1_err  = err_q[1];

endmodule

`default_nettype wire

// File: tb/tb_pu_msp430_ram_arb.sv
// ============================================================================
// Module   : tb_pu_msp430_ram_arb
// Brief    : Directed, table-driven bench for the two-port RAM arbiter with a
//            behavioural byte-writable RAM attached to the RAM side.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pu_msp430_ram_arb;

    localparam int ADDR_MSB = 7;    // wide enough to express address 128
    localparam int MEM_SIZE = 256;
    localparam int MAX_WAIT = 3;

    logic              ram_clk;
    logic              ram_rst_n;
    logic              p0_req, p1_req;
    logic [ADDR_MSB:0] p0_addr, p1_addr;
    logic [1:0]        p0_wen, p1_wen;
    logic [15:0]       p0_din, p1_din;
    logic              p0_gnt, p1_gnt;
    logic [15:0]       p0_dout, p1_dout;
    logic              p0_dvld, p1_dvld;
    logic              p0_err, p1_err;
    logic [ADDR_MSB:0] ram_addr;
    logic              ram_cen;
    logic [1:0]        ram_wen;
    logic [15:0]       ram_din;
    logic [15:0]       ram_dout;

    int checks = 0;
    int errors = 0;

    pu_msp430_ram_arb #(
        .ADDR_MSB(ADDR_MSB),
        .MEM_SIZE(MEM_SIZE),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .ram_clk  (ram_clk),
        .ram_rst_n(ram_rst_n),
        .p0_req   (p0_req),
        .p0_addr  (p0_addr),
        .p0_wen   (p0_wen),
        .p0_din   (p0_din),
        .p0_gnt   (p0_gnt),
        .p0_dout  (p0_dout),
        .p0_dvld  (p0_dvld),
        .p0_err   (p0_err),
        .p1_req   (p1_req),
        .p1_addr  (p1_addr),
        .p1_wen   (p1_wen),
        .p1_din   (p1_din),
        .p1_gnt   (p1_gnt),
        .p1_dout  (p1_dout),
        .p1_dvld  (p1_dvld),
        .p1_err   (p1_err),
        .ram_addr (ram_addr),
        .ram_cen  (ram_cen),
        .ram_wen  (ram_wen),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    initial ram_clk = 1'b0;
    always #5 ram_clk = ~ram_clk;

    // Behavioural single-port RAM with active-low byte write enables.
    logic [15:0] mem [0:255];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        ram_dout = 16'h0000;
    end
    always @(posedge ram_clk) begin
        if (!ram_cen) begin
            if (!ram_wen[0]) mem[ram_addr][7:0]  <= ram_din[7:0];
            if (!ram_wen[1]) mem[ram_addr][15:8] <= ram_din[15:8];
            ram_dout <= mem[ram_addr];
        end
    end

    typedef struct {
        logic              r0;
        logic [ADDR_MSB:0] a0;
        logic [1:0]        w0;
        logic [15:0]       d0;
        logic              r1;
        logic [ADDR_MSB:0] a1;
        logic [1:0]        w1;
        logic [15:0]       d1;
        logic [6:0]        exp_flags;  // {gnt0,gnt1,cen,dvld0,dvld1,err0,err1}
        logic [15:0]       exp_do0;
        logic [15:0]       exp_do1;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r0, input int a0, input logic [1:0] w0,
                                input logic [15:0] d0, input logic r1, input int a1,
                                input logic [1:0] w1, input logic [15:0] d1,
                                input logic [6:0] fl, input logic [15:0] o0,
                                input logic [15:0] o1);
        vec_t v;
        v.r0 = r0; v.a0 = a0[ADDR_MSB:0]; v.w0 = w0; v.d0 = d0;
        v.r1 = r1; v.a1 = a1[ADDR_MSB:0]; v.w1 = w1; v.d1 = d1;
        v.exp_flags = fl; v.exp_do0 = o0; v.exp_do1 = o1;
        return v;
    endfunction

    task automatic drive(input logic r0, input int a0, input logic [1:0] w0,
                         input logic [15:0] d0, input logic r1, input int a1,
                         input logic [1:0] w1, input logic [15:0] d1);
        p0_req = r0; p0_addr = a0[ADDR_MSB:0]; p0_wen = w0; p0_din = d0;
        p1_req = r1; p1_addr = a1[ADDR_MSB:0]; p1_wen = w1; p1_din = d1;
    endtask

    task automatic check(input string name, input logic [6:0] fl,
                         input logic [15:0] o0, input logic [15:0] o1);
        logic [38:0] act, exp;
        act = {p0_gnt, p1_gnt, ram_cen, p0_dvld, p1_dvld, p0_err, p1_err, p0_dout, p1_dout};
        exp = {fl, o0, o1};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {gnt0,gnt1,cen,v0,v1,e0,e1}=%b dout0=%h dout1=%h, want %b %h %h",
                     name, act[38:32], act[31:16], act[15:0], exp[38:32], exp[31:16], exp[15:0]);
        end
    endtask

    task automatic tick;
        @(posedge ram_clk);
        #1;
    endtask

    // Flag shorthands: {gnt0,gnt1,cen,dvld0,dvld1,err0,err1}
    localparam logic [6:0] IDLE = 7'b0010000;
    localparam logic [6:0] G0   = 7'b1000000;
    localparam logic [6:0] G1   = 7'b0100000;
    localparam logic [6:0] G0X  = 7'b1010000;   // grant, out of range
    localparam logic [6:0] G1X  = 7'b0110000;
    localparam logic [6:0] V0   = 7'b0011000;
    localparam logic [6:0] V1   = 7'b0010100;
    localparam logic [6:0] G1V0 = 7'b0101000;
    localparam logic [6:0] G1V1 = 7'b0100100;
    localparam logic [6:0] V0E0 = 7'b0011010;
    localparam logic [6:0] E1   = 7'b0010001;

    initial begin
        // Solo write then read on port 0
        vecs.push_back(mk(1,   5, 2'b00, 16'hA55A, 0,   0, 2'b11, 16'h0, G0,   16'h0000, 16'h0000));
        vecs.push_back(mk(1,   5, 2'b11, 16'h0000, 0,   0, 2'b11, 16'h0, G0,   16'h0000, 16'h0000));
        vecs.push_back(mk(0,   0, 2'b11, 16'h0000, 0,   0, 2'b11, 16'h0, V0,   16'hA55A, 16'h0000));
        vecs.push_back(mk(0,   0, 2'b11, 16'h0000, 0,   0, 2'b11, 16'h0, IDLE, 16'hA55A, 16'h0000));
        // Byte writes on port 1: full 1234, low byte EE only, then read
        vecs.push_back(mk(0,   0, 2'b11, 16'h0000, 1,   2, 2'b00, 16'h1234, G1, 16'hA55A, 16'h0000));
        vecs.push_back(mk(0,   0, 2'b11, 16'h0000, 1,   2, 2'b10, 16'hFFEE, G1, 16'hA55A, 16'h0000));
        vecs.push_back(mk(0,   0, 2'b11, 16'h0000, 1,   2, 2'b11, 16'h0000, G1, 16'hA55A, 16'h0000));
        vecs.push_back(mk(0,   0, 2'b11, 16'h0000, 0,   0, 2'b11, 16'h0, V1,   16'hA55A, 16'h12EE));
        // Out-of-range read on port 0
        vecs.push_back(mk(1, 128, 2'b11, 16'h0000, 0,   0, 2'b11, 16'h0, G0X,  16'hA55A, 16'h12EE));
        vecs.push_back(mk(0,   0, 2'b11, 16'h0000, 0,   0, 2'b11, 16'h0, V0E0, 16'h0000, 16'h12EE));
        vecs.push_back(mk(0,   0, 2'b11, 16'h0000, 0,   0, 2'b11, 16'h0, IDLE, 16'h0000, 16'h12EE));
        // Interleaved reads, then p1 overwrites addr 2 right after its read
        vecs.push_back(mk(1,   1, 2'b00, 16'h1111, 0,   0, 2'b11, 16'h0, G0,   16'h0000, 16'h12EE));
        vecs.push_back(mk(1,   1, 2'b11, 16'h0000, 0,   0, 2'b11, 16'h0, G0,   16'h0000, 16'h12EE));
        vecs.push_back(mk(0,   0, 2'b11, 16'h0000, 1,   2, 2'b11, 16'h0000, G1V0, 16'h1111, 16'h12EE));
        vecs.push_back(mk(0,   0, 2'b11, 16'h0000, 1,   2, 2'b00, 16'hBEEF, G1V1, 16'h1111, 16'h12EE));
        vecs.push_back(mk(0,   0, 2'b11, 16'h0000, 0,   0, 2'b11, 16'h0, IDLE, 16'h1111, 16'h12EE));
        // Sustained contention (writes): p0,p0,p0,p1,p0,p0,p0,p1
        for (int k = 0; k < 8; k++) begin
            vecs.push_back(mk(1, 10, 2'b00, 16'h0000, 1, 11, 2'b00, 16'h0000,
                              (k % 4 == 3) ? G1 : G0, 16'h1111, 16'h12EE));
        end
        // Both read: p0 first, p1 next cycle
        vecs.push_back(mk(1,   5, 2'b11, 16'h0000, 1,   2, 2'b11, 16'h0000, G0,   16'h1111, 16'h12EE));
        vecs.push_back(mk(0,   0, 2'b11, 16'h0000, 1,   2, 2'b11, 16'h0000, G1V0, 16'hA55A, 16'h12EE));
        vecs.push_back(mk(0,   0, 2'b11, 16'h0000, 0,   0, 2'b11, 16'h0, V1,   16'hA55A, 16'hBEEF));
        // Out-of-range write on port 1: error pulse but no dvld
        vecs.push_back(mk(0,   0, 2'b11, 16'h0000, 1, 200, 2'b00, 16'h5555, G1X, 16'hA55A, 16'hBEEF));
        vecs.push_back(mk(0,   0, 2'b11, 16'h0000, 0,   0, 2'b11, 16'h0, E1,   16'hA55A, 16'hBEEF));
        vecs.push_back(mk(0,   0, 2'b11, 16'h0000, 0,   0, 2'b11, 16'h0, IDLE, 16'hA55A, 16'hBEEF));

        // Reset with both ports requesting: nothing may be granted
        ram_rst_n = 1'b0;
        drive(1, 3, 2'b11, 16'h0, 1, 4, 2'b11, 16'h0);
        #3;
        check("reset_outputs", IDLE, 16'h0000, 16'h0000);
        checks++;
        if (ram_wen !== 2'b11) begin
            errors++;
            $display("FAIL reset_ram_wen: got %b want 11", ram_wen);
        end
        tick();
        drive(0, 0, 2'b11, 16'h0, 0, 0, 2'b11, 16'h0);
        tick();
        ram_rst_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            drive(vecs[i].r0, int'(vecs[i].a0), vecs[i].w0, vecs[i].d0,
                  vecs[i].r1, int'(vecs[i].a1), vecs[i].w1, vecs[i].d1);
            #3;
            check($sformatf("row%0d", i), vecs[i].exp_flags, vecs[i].exp_do0, vecs[i].exp_do1);
            tick();
        end

        // Reset in the middle of a granted read, with starvation already built up
        drive(1, 10, 2'b00, 16'h0, 1, 11, 2'b00, 16'h0);
        #3; check("pre_rst_g0a", G0, 16'hA55A, 16'hBEEF); tick();
        drive(1,  5, 2'b11, 16'h0, 1, 11, 2'b00, 16'h0);
        #3; check("pre_rst_read", G0, 16'hA55A, 16'hBEEF);
        ram_rst_n = 1'b0;
        #1; check("mid_rst", IDLE, 16'h0000, 16'h0000);
        drive(0, 0, 2'b11, 16'h0, 0, 0, 2'b11, 16'h0);
        tick(); tick();
        ram_rst_n = 1'b1;
        #3; check("post_rst_idle", IDLE, 16'h0000, 16'h0000);
        tick();
        // Starvation counter must start from zero again: p0,p0,p0,p1
        for (int k = 0; k < 4; k++) begin
            drive(1, 10, 2'b00, 16'h0, 1, 11, 2'b00, 16'h0);
            #3;
            check($sformatf("post_rst_cont%0d", k), (k == 3) ? G1 : G0, 16'h0000, 16'h0000);
            tick();
        end
        drive(0, 0, 2'b11, 16'h0, 0, 0, 2'b11, 16'h0);
        #3; check("post_rst_quiet", IDLE, 16'h0000, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
